// File: rtl/btn_irq_req.sv
// Press-event queue with a level irq/ack handshake and a fixed low gap after each acknowledge.
// Optional BTN_RELEASE_IRQ_EN: count release edges as well as press edges.
module btn_irq_req #(
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             db,
  input  logic             irq_en,
  input  logic             irq_ack,
  input  logic             ovf_clr,
  output logic             irq,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYC - 1);

  state_t     state, state_nxt;
  logic [7:0] gap_cnt, gap_nxt;
  logic       db_q, armed;
  logic       evt, ack_ok, sat;

  // armed masks the first cycle out of reset so a button held through reset is not seen as a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      db_q  <= db;
      armed <= 1'b1;
    end
  end

`ifdef BTN_RELEASE_IRQ_EN
  assign evt = (db ^ db_q) & irq_en & armed;
`else
  assign evt = db & ~db_q & irq_en & armed;
`endif

  assign ack_ok = irq_ack & (state == REQ);
  assign sat    = evt & ~ack_ok & (pend_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (evt && !ack_ok) begin
        if (pend_cnt != CNT_MAX) pend_cnt <= pend_cnt + CNT_W'(1);
      end else if (ack_ok && !evt) begin
        pend_cnt <= pend_cnt - CNT_W'(1);
      end
      if (sat)          ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: if (pend_cnt != '0) state_nxt = REQ;
      REQ: begin
        if (ack_ok) begin
          state_nxt = GAP;
          gap_nxt   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt != 8'd0) gap_nxt   = gap_cnt - 8'd1;
        else                 state_nxt = (pend_cnt != '0) ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign irq = (state == REQ);

endmodule
